// File: rtl/frogger_pkg.sv
// Shared types and default playfield geometry for the Frogger traffic engine
// and the LED display driver.
package frogger_pkg;

  // Direction of travel for one lane of traffic.
  typedef enum logic {
    DIR_DOWN = 1'b0,  // enter at bit WIDTH-1, move toward bit 0
    DIR_UP   = 1'b1   // enter at bit 0, move toward bit WIDTH-1
  } lane_dir_e;

  // Default playfield geometry, shared with the display driver.
  localparam int DEF_WIDTH = 16;
  localparam int DEF_LANES = 4;

  // Cell where new or wrapped cars appear for a given direction.
  function automatic int entry_cell(input lane_dir_e dir, input int width);
    return (dir == DIR_UP) ? 0 : width - 1;
  endfunction

  // Cell a car occupies just before it leaves the lane.
  function automatic int exit_cell(input lane_dir_e dir, input int width);
    return (dir == DIR_UP) ? width - 1 : 0;
  endfunction

endpackage

// File: rtl/car_lane.sv
// One lane of traffic: speed divider, pending-insertion flag, occupancy shift
// register and a registered step strobe. The post-update occupancy is exported
// so the bank can compute a collision flag aligned with the registered cells.
module car_lane
  import frogger_pkg::*;
#(
  parameter int        WIDTH    = 16,
  parameter int        PERIOD_W = 4,
  parameter lane_dir_e DIR      = DIR_UP
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                tick,
  input  logic                add_car,
  input  logic [PERIOD_W-1:0] period,
  input  logic                wrap,
  output logic [WIDTH-1:0]    cells,
  output logic [WIDTH-1:0]    cells_next,
  output logic                step
);

  localparam int ENTRY = entry_cell(DIR, WIDTH);
  localparam int EXIT  = exit_cell(DIR, WIDTH);

  logic [PERIOD_W-1:0] cnt;
  logic                pending;

  logic                fire;
  logic                pending_eff;
  logic                wrap_in;
  logic                insert;
  logic [WIDTH-1:0]    shifted;

  // Divider decision, gap-rule insertion and next occupancy.
  // ">=" lets a period lowered mid-count fire on the very next tick.
  // A car wrapping into the entry cell takes priority; insertion then waits.
  always_comb begin
    fire        = tick & (cnt >= period);
    pending_eff = pending | add_car;
    wrap_in     = wrap & cells[EXIT];
    insert      = fire & pending_eff & ~cells[ENTRY] & ~wrap_in;
    if (DIR == DIR_UP) begin
      shifted = {cells[WIDTH-2:0], 1'b0};
    end else begin
      shifted = {1'b0, cells[WIDTH-1:1]};
    end
    shifted[ENTRY] = wrap_in | insert;
    cells_next     = fire ? shifted : cells;
  end

  // Lane state update; reset clears occupancy, divider, pending and step.
  always_ff @(posedge clock) begin
    if (reset) begin
      cells   <= '0;
      cnt     <= '0;
      pending <= 1'b0;
      step    <= 1'b0;
    end else begin
      cells   <= cells_next;
      step    <= fire;
      pending <= pending_eff & ~insert;
      if (fire) begin
        cnt <= '0;
      end else if (tick) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/car_lane_bank.sv
// Multi-lane car traffic engine for the Frogger playfield. Instantiates one
// car_lane per lane and produces a registered frog/car collision flag that is
// aligned with the registered occupancy output.
module car_lane_bank
  import frogger_pkg::*;
#(
  parameter int               WIDTH    = DEF_WIDTH,
  parameter int               LANES    = DEF_LANES,
  parameter logic [LANES-1:0] DIR_MASK = 4'b0101,
  parameter int               PERIOD_W = 4,
  localparam int              LW       = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int              CW       = $clog2(WIDTH)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      tick,
  input  logic [LANES-1:0]          add_car,
  input  logic [LANES*PERIOD_W-1:0] lane_period,
  input  logic                      wrap,
  input  logic                      frog_valid,
  input  logic [LW-1:0]             frog_lane,
  input  logic [CW-1:0]             frog_col,
  output logic [LANES*WIDTH-1:0]    lanes,
  output logic [LANES-1:0]          step,
  output logic                      hit
);

  logic [LANES*WIDTH-1:0] lanes_next;
  logic                   hit_next;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    car_lane #(
      .WIDTH    (WIDTH),
      .PERIOD_W (PERIOD_W),
      .DIR      (lane_dir_e'(DIR_MASK[g]))
    ) u_lane (
      .clock      (clock),
      .reset      (reset),
      .tick       (tick),
      .add_car    (add_car[g]),
      .period     (lane_period[g*PERIOD_W +: PERIOD_W]),
      .wrap       (wrap),
      .cells      (lanes[g*WIDTH +: WIDTH]),
      .cells_next (lanes_next[g*WIDTH +: WIDTH]),
      .step       (step[g])
    );
  end

  // Collision against the post-update occupancy; a lane index with no
  // matching lane leaves the flag low.
  always_comb begin
    logic [WIDTH-1:0] row;
    hit_next = 1'b0;
    row      = '0;
    for (int i = 0; i < LANES; i++) begin
      if (frog_lane == LW'(i)) begin
        row      = lanes_next[i*WIDTH +: WIDTH];
        hit_next = frog_valid & row[frog_col];
      end
    end
  end

  // Registered collision flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      hit <= 1'b0;
    end else begin
      hit <= hit_next;
    end
  end

endmodule

// File: tb/tb_car_lane_bank.sv
// Testbench for car_lane_bank: directed vector table, hand-written multi-cycle
// sequences and a randomized run checked against a cell-array reference model.
module tb_car_lane_bank;

  localparam int W  = 16;
  localparam int L  = 4;
  localparam int PW = 4;
  localparam logic [L-1:0] MASK = 4'b0101;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          tick = 1'b0;
  logic [L-1:0]  add_car = '0;
  logic [L*PW-1:0] lane_period = '0;
  logic          wrap = 1'b0;
  logic          frog_valid = 1'b0;
  logic [1:0]    frog_lane = '0;
  logic [3:0]    frog_col = '0;
  logic [L*W-1:0] lanes;
  logic [L-1:0]  step;
  logic          hit;

  always #5 clock = ~clock;

  car_lane_bank #(
    .WIDTH(W), .LANES(L), .DIR_MASK(MASK), .PERIOD_W(PW)
  ) dut (
    .clock(clock), .reset(reset), .tick(tick), .add_car(add_car),
    .lane_period(lane_period), .wrap(wrap), .frog_valid(frog_valid),
    .frog_lane(frog_lane), .frog_col(frog_col),
    .lanes(lanes), .step(step), .hit(hit)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: each lane is an array of cells with an explicit
  // tick countdown and a pending-car request.
  int          mcell[L][W];
  int          mcnt[L];
  bit          mpend[L];
  logic [63:0] m_lanes;
  logic [3:0]  m_step;
  logic        m_hit;

  task automatic model_edge();
    int nw[W];
    int entry, ex, per;
    bit fired, wrapped;
    m_step = '0;
    if (reset) begin
      for (int l = 0; l < L; l++) begin
        for (int c = 0; c < W; c++) mcell[l][c] = 0;
        mcnt[l] = 0;
        mpend[l] = 0;
      end
      m_hit = 1'b0;
    end else begin
      for (int l = 0; l < L; l++) begin
        if (add_car[l]) mpend[l] = 1;
        fired = 0;
        if (tick) begin
          per = int'(lane_period[l*PW +: PW]);
          if (mcnt[l] >= per) begin
            fired = 1;
            mcnt[l] = 0;
          end else begin
            mcnt[l]++;
          end
        end
        if (fired) begin
          entry = MASK[l] ? 0 : W - 1;
          ex    = W - 1 - entry;
          for (int c = 0; c < W; c++) begin
            if (c == entry) nw[c] = 0;
            else nw[c] = MASK[l] ? mcell[l][c-1] : mcell[l][c+1];
          end
          wrapped = wrap && (mcell[l][ex] != 0);
          if (wrapped) nw[entry] = 1;
          else if (mpend[l] && mcell[l][entry] == 0) begin
            nw[entry] = 1;
            mpend[l] = 0;
          end
          for (int c = 0; c < W; c++) mcell[l][c] = nw[c];
        end
        m_step[l] = fired;
      end
      m_hit = frog_valid && (int'(frog_lane) < L) && (mcell[frog_lane][frog_col] != 0);
    end
    for (int l = 0; l < L; l++)
      for (int c = 0; c < W; c++)
        m_lanes[l*W + c] = (mcell[l][c] != 0);
  endtask

  // One clock edge; the model follows every edge and optionally is compared.
  task automatic cyc(input bit do_chk);
    @(posedge clock);
    model_edge();
    #1;
    if (do_chk) begin
      chk("rand_lanes", lanes, m_lanes);
      chk("rand_step", {60'd0, step}, {60'd0, m_step});
      chk("rand_hit", {63'd0, hit}, {63'd0, m_hit});
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; tick = 1'b0; add_car = '0; wrap = 1'b0;
    frog_valid = 1'b0; lane_period = '0;
    cyc(0);
    reset = 1'b0;
  endtask

  typedef struct {
    logic        rst;
    logic        tk;
    logic [3:0]  add;
    logic        fv;
    logic [1:0]  fl;
    logic [3:0]  fc;
    logic [63:0] e_lanes;
    logic [3:0]  e_step;
    logic        e_hit;
  } vec_t;

  function automatic vec_t mk(logic rst, logic tk, logic [3:0] add, logic fv,
                              logic [1:0] fl, logic [3:0] fc, logic [63:0] el,
                              logic [3:0] es, logic eh);
    vec_t v;
    v.rst = rst; v.tk = tk; v.add = add; v.fv = fv; v.fl = fl; v.fc = fc;
    v.e_lanes = el; v.e_step = es; v.e_hit = eh;
    return v;
  endfunction

  vec_t tbl[$];
  int   nsteps;

  initial begin
    // Periods 0, wrap 0: every tick shifts every lane.
    tbl.push_back(mk(1, 0, 4'h0, 0, 0, 0, 64'h0, 4'h0, 0));
    tbl.push_back(mk(0, 0, 4'h1, 0, 0, 0, 64'h0, 4'h0, 0));
    tbl.push_back(mk(0, 1, 4'h0, 1, 0, 2, 64'h0001, 4'hF, 0));
    tbl.push_back(mk(0, 1, 4'h0, 1, 0, 2, 64'h0002, 4'hF, 0));
    tbl.push_back(mk(0, 1, 4'h0, 1, 0, 2, 64'h0004, 4'hF, 1));
    tbl.push_back(mk(0, 0, 4'h0, 1, 0, 2, 64'h0004, 4'h0, 1));
    tbl.push_back(mk(0, 0, 4'h0, 0, 0, 2, 64'h0004, 4'h0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 1, 3, 2, 64'h0004, 4'h0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 1, 0, 2, 64'h0004, 4'h0, 1));
    // Hold add_car[1]: gap rule spaces cars every other cell.
    tbl.push_back(mk(0, 0, 4'h2, 0, 0, 0, 64'h0004, 4'h0, 0));
    tbl.push_back(mk(0, 1, 4'h2, 0, 0, 0, 64'h8000_0008, 4'hF, 0));
    tbl.push_back(mk(0, 1, 4'h2, 0, 0, 0, 64'h4000_0010, 4'hF, 0));
    tbl.push_back(mk(0, 1, 4'h2, 0, 0, 0, 64'hA000_0020, 4'hF, 0));
    tbl.push_back(mk(0, 1, 4'h2, 0, 0, 0, 64'h5000_0040, 4'hF, 0));
    tbl.push_back(mk(0, 1, 4'h0, 1, 1, 15, 64'hA800_0080, 4'hF, 1));
    tbl.push_back(mk(0, 0, 4'h0, 1, 1, 14, 64'hA800_0080, 4'h0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; tick = tbl[i].tk; add_car = tbl[i].add;
      frog_valid = tbl[i].fv; frog_lane = tbl[i].fl; frog_col = tbl[i].fc;
      cyc(0);
      chk($sformatf("vec%0d_lanes", i), lanes, tbl[i].e_lanes);
      chk($sformatf("vec%0d_step", i), {60'd0, step}, {60'd0, tbl[i].e_step});
      chk($sformatf("vec%0d_hit", i), {63'd0, hit}, {63'd0, tbl[i].e_hit});
    end
    tick = 1'b0; add_car = '0; frog_valid = 1'b0;

    // 17 ticks without wrap: the car leaves the lane.
    do_reset();
    add_car = 4'h1; cyc(0); add_car = '0;
    tick = 1'b1;
    for (int i = 0; i < 17; i++) cyc(0);
    tick = 1'b0;
    chk("nowrap_lanes", lanes, 64'h0);

    // 17 ticks with wrap: the car re-enters at bit 0.
    do_reset();
    wrap = 1'b1;
    add_car = 4'h1; cyc(0); add_car = '0;
    tick = 1'b1;
    for (int i = 0; i < 16; i++) cyc(0);
    chk("wrap_at_exit", lanes, 64'h8000);
    cyc(0);
    tick = 1'b0;
    chk("wrap_lanes", lanes, 64'h0001);
    wrap = 1'b0;

    // Lane 2 at period 3: shifts on ticks 4 and 8 only.
    do_reset();
    lane_period = 16'h0300;
    add_car = 4'h4; cyc(0); add_car = '0;
    nsteps = 0;
    for (int i = 0; i < 8; i++) begin
      tick = 1'b1; cyc(0);
      if (step[2]) nsteps++;
      tick = 1'b0; cyc(0);
      if (step[2]) nsteps++;
    end
    chk("period3_steps", 64'(nsteps), 64'd2);
    chk("period3_lanes", lanes, 64'h0000_0002_0000_0000);
    for (int i = 0; i < 5; i++) cyc(0);
    chk("idle_lanes", lanes, 64'h0000_0002_0000_0000);
    chk("idle_step", {60'd0, step}, 64'h0);

    // Lowering the period mid-count fires on the next tick.
    do_reset();
    lane_period = 16'h0007;
    tick = 1'b1;
    for (int i = 0; i < 3; i++) cyc(0);
    chk("slow_no_step", {60'd0, step}, 64'h0E);
    lane_period = 16'h0001;
    cyc(0);
    tick = 1'b0;
    chk("lowered_step", {60'd0, step}, 64'h0F);

    // Reset before any tick discards a pending car; add_car ignored under reset.
    do_reset();
    add_car = 4'h8; cyc(0);
    reset = 1'b1; cyc(0);
    add_car = '0; reset = 1'b0;
    tick = 1'b1;
    for (int i = 0; i < 2; i++) cyc(0);
    chk("rst_pending_lanes", lanes, 64'h0);
    for (int i = 0; i < 3; i++) cyc(0);
    tick = 1'b0;
    chk("rst_pending_later", lanes, 64'h0);

    // Randomized run against the reference model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      tick  = $urandom_range(0, 1);
      for (int l = 0; l < L; l++) add_car[l] = ($urandom_range(0, 3) == 0);
      if (i % 64 == 0) wrap = $urandom_range(0, 1);
      if (i % 40 == 0)
        for (int l = 0; l < L; l++) lane_period[l*PW +: PW] = PW'($urandom_range(0, 3));
      frog_valid = $urandom_range(0, 1);
      frog_lane  = 2'($urandom_range(0, 3));
      frog_col   = 4'($urandom_range(0, 15));
      cyc(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
